// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - IF/ID capture, B/CBZ decode and one-cycle PC redirect back to fetch.
// Three-state FSM: IDLE captures a valid fetch, DECODE resolves the branch, ISSUE retires the redirect.

module branch_resolver #(
    parameter logic [3:0] OP_B   = 4'b0010,
    parameter logic [3:0] OP_CBZ = 4'b0011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        NOP,
    input  logic [15:0] instr,
    input  logic        reg_zero,
    output logic [2:0]  cbz_reg,
    output logic        PCsrc,
    output logic [15:0] target,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic        id_valid,
    output logic [7:0]  taken_cnt,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    state_t state, state_n;

    logic        capture;
    logic        take;
    logic        consume;
    logic [15:0] tgt;
    logic [3:0]  op;
    logic [15:0] off_b;
    logic [15:0] off_cbz;

    assign op      = id_instr[15:12];
    assign cbz_reg = id_instr[11:9];

    // Offsets are halfword counts, so the shift keeps targets even.
    assign off_b   = {{3{id_instr[11]}}, id_instr[11:0], 1'b0};
    assign off_cbz = {{6{id_instr[8]}}, id_instr[8:0], 1'b0};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        take    = 1'b0;
        consume = 1'b0;
        tgt     = 16'h0000;
        unique case (state)
            IDLE: begin
                if (!NOP) begin
                    capture = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                if (op == OP_B) begin
                    take    = 1'b1;
                    tgt     = id_pc + off_b;
                    state_n = ISSUE;
                end else if (op == OP_CBZ && reg_zero) begin
                    take    = 1'b1;
                    tgt     = id_pc + off_cbz;
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                consume = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            PCsrc     <= 1'b0;
            target    <= 16'h0000;
            id_instr  <= 16'h0000;
            id_pc     <= 16'h0000;
            id_valid  <= 1'b0;
            taken_cnt <= 8'h00;
            misalign  <= 1'b0;
        end else begin
            if (capture) begin
                id_instr <= instr;
                id_pc    <= pc;
                id_valid <= 1'b1;
            end
            if (take) begin
                target <= tgt;
                PCsrc  <= 1'b1;
                if (tgt[0]) begin
                    misalign <= 1'b1;
                end
            end
            if (consume) begin
                PCsrc     <= 1'b0;
                taken_cnt <= taken_cnt + 8'd1;
                id_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed table-driven bench for branch_resolver.
// Inputs change and outputs are sampled 1ns after each rising clock edge.

module tb_branch_resolver;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        NOP;
    logic [15:0] instr;
    logic        reg_zero;
    logic [2:0]  cbz_reg;
    logic        PCsrc;
    logic [15:0] target;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_valid;
    logic [7:0]  taken_cnt;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    branch_resolver dut (
        .clock    (clock),
        .reset    (reset),
        .pc       (pc),
        .NOP      (NOP),
        .instr    (instr),
        .reg_zero (reg_zero),
        .cbz_reg  (cbz_reg),
        .PCsrc    (PCsrc),
        .target   (target),
        .id_instr (id_instr),
        .id_pc    (id_pc),
        .id_valid (id_valid),
        .taken_cnt(taken_cnt),
        .misalign (misalign)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        rz;
        logic [2:0]  creg;
        logic        taken;
        logic [15:0] tgt;
        logic [7:0]  cnt;
        logic        mis;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = '{16'h0010, 16'h2003, 1'b0, 3'd0, 1'b1, 16'h0016, 8'd1, 1'b0};
        vecs[1] = '{16'h0020, 16'h3BFE, 1'b1, 3'd5, 1'b1, 16'h001C, 8'd2, 1'b0};
        vecs[2] = '{16'h0020, 16'h3BFE, 1'b0, 3'd5, 1'b0, 16'h0000, 8'd2, 1'b0};
        vecs[3] = '{16'hFFFE, 16'h2002, 1'b0, 3'd0, 1'b1, 16'h0002, 8'd3, 1'b0};
        vecs[4] = '{16'h0040, 16'h1234, 1'b1, 3'd1, 1'b0, 16'h0000, 8'd3, 1'b0};
        vecs[5] = '{16'h0100, 16'h2FFF, 1'b0, 3'd7, 1'b1, 16'h00FE, 8'd4, 1'b0};
        vecs[6] = '{16'h0200, 16'h36FF, 1'b1, 3'd3, 1'b1, 16'h03FE, 8'd5, 1'b0};
        vecs[7] = '{16'h0011, 16'h2000, 1'b0, 3'd0, 1'b1, 16'h0011, 8'd6, 1'b1};
        vecs[8] = '{16'h0030, 16'h2001, 1'b0, 3'd0, 1'b1, 16'h0032, 8'd7, 1'b1};

        // Reset held while a valid B is presented: nothing may leak out.
        reset    = 1'b1;
        NOP      = 1'b0;
        pc       = 16'h0010;
        instr    = 16'h2003;
        reg_zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_pcsrc", {31'd0, PCsrc}, 32'd0);
        end
        chk("rst_target", {16'd0, target}, 32'd0);
        chk("rst_id_instr", {16'd0, id_instr}, 32'd0);
        chk("rst_id_pc", {16'd0, id_pc}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_cnt", {24'd0, taken_cnt}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        reset = 1'b0;
        NOP   = 1'b1;
        step();

        // Each vector starts in the cycle the previous one was checked: back-to-back issue.
        for (int i = 0; i < 9; i++) begin
            NOP   = 1'b0;
            pc    = vecs[i].pc;
            instr = vecs[i].instr;
            step();
            NOP      = 1'b1;
            reg_zero = vecs[i].rz;
            chk($sformatf("v%0d_id_pc", i), {16'd0, id_pc}, {16'd0, vecs[i].pc});
            chk($sformatf("v%0d_id_instr", i), {16'd0, id_instr}, {16'd0, vecs[i].instr});
            chk($sformatf("v%0d_id_valid", i), {31'd0, id_valid}, 32'd1);
            chk($sformatf("v%0d_cbz_reg", i), {29'd0, cbz_reg}, {29'd0, vecs[i].creg});
            chk($sformatf("v%0d_pcsrc_early", i), {31'd0, PCsrc}, 32'd0);
            step();
            reg_zero = 1'b0;
            chk($sformatf("v%0d_pcsrc", i), {31'd0, PCsrc}, {31'd0, vecs[i].taken});
            if (vecs[i].taken)
                chk($sformatf("v%0d_target", i), {16'd0, target}, {16'd0, vecs[i].tgt});
            step();
            chk($sformatf("v%0d_pcsrc_late", i), {31'd0, PCsrc}, 32'd0);
            chk($sformatf("v%0d_cnt", i), {24'd0, taken_cnt}, {24'd0, vecs[i].cnt});
            chk($sformatf("v%0d_mis", i), {31'd0, misalign}, {31'd0, vecs[i].mis});
            chk($sformatf("v%0d_id_valid_late", i), {31'd0, id_valid}, {31'd0, !vecs[i].taken});
        end

        // NOP=0 glitch during DECODE of a non-branch must not be captured.
        NOP   = 1'b0;
        pc    = 16'h0040;
        instr = 16'h1234;
        step();
        pc    = 16'h0500;
        instr = 16'h2003;
        step();
        NOP = 1'b1;
        chk("glitch_pcsrc", {31'd0, PCsrc}, 32'd0);
        chk("glitch_id_pc", {16'd0, id_pc}, 32'h0040);
        step();
        chk("glitch_pcsrc2", {31'd0, PCsrc}, 32'd0);
        chk("glitch_cnt", {24'd0, taken_cnt}, 32'd7);

        // Reset sampled during DECODE of a B aborts the redirect.
        NOP   = 1'b0;
        pc    = 16'h0010;
        instr = 16'h2003;
        step();
        NOP   = 1'b1;
        reset = 1'b1;
        step();
        chk("abort_pcsrc", {31'd0, PCsrc}, 32'd0);
        chk("abort_id_valid", {31'd0, id_valid}, 32'd0);
        chk("abort_cnt", {24'd0, taken_cnt}, 32'd0);
        chk("abort_mis", {31'd0, misalign}, 32'd0);
        reset = 1'b0;
        step();
        chk("abort_pcsrc2", {31'd0, PCsrc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
